m7seg_decoder: RTL and testbench

M7SEG_DECODER -- requirements
Module: m7seg_decoder

---
 rtl/m7seg_decoder_pkg.sv | 18 +
 rtl/m7seg_display6.sv | 30 +++
 rtl/m7seg_decoder.sv | 43 ++++
 tb/tb_m7seg_decoder.sv | 110 +++++++++++
 4 files changed

// File: rtl/m7seg_decoder_pkg.sv
// Shared seven-segment constants and the active-high hex glyph table (gfedcba order).
package m7seg_decoder_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_ALL_ON  = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_ALL_OFF = 7'h00;

    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/m7seg_display6.sv
// Board-level six-digit display: one decoder per nibble of a 24-bit value, digit 0 in the low bits.
module m7seg_display6
    import m7seg_decoder_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               blank,
    input  logic               lamp_test,
    input  logic [23:0]        value,
    output logic [6*SEG_W-1:0] segments
);

    for (genvar g = 0; g < 6; g++) begin : g_digit
        m7seg_decoder #(
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_digit (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .blank    (blank),
            .lamp_test(lamp_test),
            .hex_num  (value[4*g +: 4]),
            .segment  (segments[SEG_W*g +: SEG_W])
        );
    end

endmodule

// File: rtl/m7seg_decoder.sv
// Registered hex-to-seven-segment decoder with lamp test, blanking and selectable polarity.
module m7seg_decoder
    import m7seg_decoder_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             blank,
    input  logic             lamp_test,
    input  logic [3:0]       hex_num,
    output logic [SEG_W-1:0] segment
);

    localparam logic [SEG_W-1:0] POL_MASK = {SEG_W{ACTIVE_LOW}};

    logic [SEG_W-1:0] lit_pattern;
    logic [SEG_W-1:0] segment_d;
    logic [SEG_W-1:0] segment_q;

    always_comb begin
        lit_pattern = seg_decode(hex_num);
        if (lamp_test) begin
            lit_pattern = SEG_ALL_ON;
        end else if (blank) begin
            lit_pattern = SEG_ALL_OFF;
        end
        // Polarity is applied exactly once, here at the register input.
        segment_d = en ? (lit_pattern ^ POL_MASK) : segment_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segment_q <= SEG_ALL_OFF ^ POL_MASK;
        end else begin
            segment_q <= segment_d;
        end
    end

    assign segment = segment_q;

endmodule

// File: tb/tb_m7seg_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed active-low expectations, a monitor pops one per edge.
module tb_m7seg_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;
    logic [3:0] hex_num = 4'h0;
    logic [6:0] seg_al;
    logic [6:0] seg_ah;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [6:0] exp_q[$];
    logic [6:0] prev_exp;
    bit         prev_valid = 1'b0;

    localparam logic [6:0] AL_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;

    m7seg_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .blank(blank),
        .lamp_test(lamp_test), .hex_num(hex_num), .segment(seg_al)
    );

    m7seg_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .rst(rst), .en(en), .blank(blank),
        .lamp_test(lamp_test), .hex_num(hex_num), .segment(seg_ah)
    );

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectations are stated for the active-low part; the active-high part is their complement.
    task automatic step(input logic r, input logic e, input logic b, input logic lt,
                        input logic [3:0] h, input logic [6:0] exp);
        @(negedge clk);
        rst = r; en = e; blank = b; lamp_test = lt; hex_num = h;
        exp_q.push_back(exp);
        #1;
        if (prev_valid) begin
            check("hold_before_edge_al", seg_al, prev_exp);
            check("hold_before_edge_ah", seg_ah, ~prev_exp);
        end
        prev_exp = exp;
        prev_valid = 1'b1;
    endtask

    initial begin : monitor
        logic [6:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seg_al", seg_al, e);
                check("seg_ah", seg_ah, ~e);
            end
        end
    end

    initial begin : stimulus
        int unsigned waited;
        step(1, 0, 0, 0, 4'h0, 7'h7F);
        step(1, 0, 0, 0, 4'h0, 7'h7F);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0, 4'(i), AL_TABLE[i]);
        end
        step(0, 1, 0, 0, 4'h5, 7'h12);
        step(0, 0, 0, 0, 4'hA, 7'h12);
        step(0, 0, 1, 1, 4'hA, 7'h12);
        step(0, 1, 1, 1, 4'h3, 7'h00);
        step(0, 1, 1, 0, 4'h3, 7'h7F);
        step(0, 1, 0, 0, 4'h3, 7'h30);
        step(0, 1, 0, 0, 4'h2, 7'h24);
        step(1, 1, 0, 1, 4'h2, 7'h7F);
        step(0, 0, 0, 0, 4'h2, 7'h7F);
        step(0, 1, 0, 0, 4'h2, 7'h24);
        step(0, 1, 0, 0, 4'h1, 7'h79);
        step(0, 1, 0, 0, 4'h7, 7'h78);
        step(0, 1, 0, 0, 4'h8, 7'h00);
        step(0, 1, 0, 0, 4'hB, 7'h03);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
